// File: rtl/ram_2r_w_s_mcast_fifo_ctl.sv
// ram_2r_w_s_mcast_fifo_ctl: one write pointer, two read pointers and their occupancy counts.
// Together they deliver one producer stream to two consumers through a 2R/1W DFF RAM.
module ram_2r_w_s_mcast_fifo_ctl #(
    parameter int depth      = 8,
    parameter int addr_width = 3,
    parameter int cnt_width  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_req_n,
    input  logic                  pop1_req_n,
    input  logic                  pop2_req_n,
    output logic                  ram_cs_n,
    output logic                  ram_wr_n,
    output logic [addr_width-1:0] ram_wr_addr,
    output logic [addr_width-1:0] ram_rd1_addr,
    output logic [addr_width-1:0] ram_rd2_addr,
    output logic                  full,
    output logic                  empty1,
    output logic                  empty2,
    output logic [cnt_width-1:0]  count1,
    output logic [cnt_width-1:0]  count2,
    output logic                  ovf_err,
    output logic                  udf_err
);
    localparam logic [addr_width-1:0] LAST    = addr_width'(depth - 1);
    localparam logic [cnt_width-1:0]  DEPTH_C = cnt_width'(depth);

    logic [addr_width-1:0] r_wr_ptr, r_rd1_ptr, r_rd2_ptr;
    logic [cnt_width-1:0]  r_cnt1, r_cnt2, w_cnt1_nxt, w_cnt2_nxt;
    logic                  r_full, r_empty1, r_empty2, r_ovf, r_udf;
    logic                  w_push_ok, w_pop1_ok, w_pop2_ok;

    // Explicit wrap so non-power-of-2 depths stay inside the RAM.
    function automatic logic [addr_width-1:0] f_inc(input logic [addr_width-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_push_ok  = rst_n && !push_req_n && !r_full;
        w_pop1_ok  = rst_n && !pop1_req_n && !r_empty1;
        w_pop2_ok  = rst_n && !pop2_req_n && !r_empty2;
        w_cnt1_nxt = r_cnt1 + cnt_width'(w_push_ok) - cnt_width'(w_pop1_ok);
        w_cnt2_nxt = r_cnt2 + cnt_width'(w_push_ok) - cnt_width'(w_pop2_ok);
    end

    assign ram_cs_n     = !w_push_ok;
    assign ram_wr_n     = !w_push_ok;
    assign ram_wr_addr  = r_wr_ptr;
    assign ram_rd1_addr = r_rd1_ptr;
    assign ram_rd2_addr = r_rd2_ptr;
    assign full         = r_full;
    assign empty1       = r_empty1;
    assign empty2       = r_empty2;
    assign count1       = r_cnt1;
    assign count2       = r_cnt2;
    assign ovf_err      = r_ovf;
    assign udf_err      = r_udf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd1_ptr <= '0;
            r_rd2_ptr <= '0;
            r_cnt1    <= '0;
            r_cnt2    <= '0;
            r_full    <= 1'b0;
            r_empty1  <= 1'b1;
            r_empty2  <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_wr_ptr  <= w_push_ok ? f_inc(r_wr_ptr) : r_wr_ptr;
            r_rd1_ptr <= w_pop1_ok ? f_inc(r_rd1_ptr) : r_rd1_ptr;
            r_rd2_ptr <= w_pop2_ok ? f_inc(r_rd2_ptr) : r_rd2_ptr;
            r_cnt1    <= w_cnt1_nxt;
            r_cnt2    <= w_cnt2_nxt;
            r_full    <= (w_cnt1_nxt == DEPTH_C) || (w_cnt2_nxt == DEPTH_C);
            r_empty1  <= (w_cnt1_nxt == '0);
            r_empty2  <= (w_cnt2_nxt == '0);
            r_ovf     <= r_ovf || (!push_req_n && r_full);
            r_udf     <= r_udf || (!pop1_req_n && r_empty1) || (!pop2_req_n && r_empty2);
        end
    end
endmodule
